// File: rtl/egr_mim_rd_sched_if.sv
// Requester-side and MIM-side read request signals of egr_mim_rd_sched.
// master: requesters/MIM model; slave: the scheduler itself.
interface egr_mim_rd_sched_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 20
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic                    mim_rd_req_valid;
    logic [ADDR_W-1:0]       mim_rd_req_addr;
    logic [ID_W-1:0]         mim_rd_req_id;
    logic                    mim_rd_req_ready;
    logic                    mim_rd_rsp_valid;

    modport master (
        output req_valid, req_addr, mim_rd_req_ready, mim_rd_rsp_valid,
        input  req_ready, mim_rd_req_valid, mim_rd_req_addr, mim_rd_req_id
    );

    modport slave (
        input  req_valid, req_addr, mim_rd_req_ready, mim_rd_rsp_valid,
        output req_ready, mim_rd_req_valid, mim_rd_req_addr, mim_rd_req_id
    );
endinterface

// File: rtl/egr_mim_rd_sched.sv
// Credit-limited round-robin scheduler for N_REQ requesters onto one MIM read port.
// Optional macro EGR_MIM_RD_SCHED_PRIO_EN gives requester 0 strict priority.
module egr_mim_rd_sched #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 20,
    parameter int MAX_OUTST = 8,
    localparam int ID_W     = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic               clk,
    input  logic               arst_n,
    egr_mim_rd_sched_if.slave  bus,
    input  logic               cfg_en,
    input  logic [CNT_W-1:0]   cfg_credit_max,
    output logic [CNT_W-1:0]   outstanding,
    output logic               idle
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [ID_W-1:0]   hold_id_q, hold_id_d;
    logic [CNT_W-1:0]  outst_q, outst_d;

    logic [CNT_W-1:0]  eff_limit;
    logic [CNT_W:0]    in_flight;
    logic              accept, out_free, can_grant, grant;
    logic              gnt_found, rr_upd;
    logic [ID_W-1:0]   gnt_idx, cand;
    logic              rsp_dec;

    // Credit gate: a held-but-unaccepted request already consumes a credit.
    always_comb begin
        eff_limit = (cfg_credit_max > CNT_W'(MAX_OUTST)) ? CNT_W'(MAX_OUTST) : cfg_credit_max;
        accept    = hold_valid_q & bus.mim_rd_req_ready;
        out_free  = ~hold_valid_q | bus.mim_rd_req_ready;
        in_flight = {1'b0, outst_q} + (CNT_W+1)'(hold_valid_q);
        can_grant = (state_q == ST_RUN) && out_free && (in_flight < {1'b0, eff_limit});
    end

    // Walk from farthest to nearest so the requester right after rr_ptr wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        rr_upd    = 1'b1;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
`ifdef EGR_MIM_RD_SCHED_PRIO_EN
        if (bus.req_valid[0]) begin
            gnt_found = 1'b1;
            gnt_idx   = '0;
            rr_upd    = 1'b0;
        end
`endif
        grant         = can_grant & gnt_found;
        bus.req_ready = '0;
        if (grant) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_id_d    = hold_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            hold_id_d    = gnt_idx;
            if (rr_upd) rr_ptr_d = gnt_idx;
        end else if (accept) begin
            hold_valid_d = 1'b0;
        end

        rsp_dec = bus.mim_rd_rsp_valid && (outst_q != '0);
        case ({accept, rsp_dec})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cfg_en) state_d = ST_RUN;
            ST_RUN:   if (!cfg_en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (cfg_en)                                 state_d = ST_RUN;
                else if (outst_q == '0 && !hold_valid_q)   state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= ID_W'(N_REQ - 1);
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_id_q    <= '0;
            outst_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_id_q    <= hold_id_d;
            outst_q      <= outst_d;
        end
    end

    assign bus.mim_rd_req_valid = hold_valid_q;
    assign bus.mim_rd_req_addr  = hold_addr_q;
    assign bus.mim_rd_req_id    = hold_id_q;
    assign outstanding          = outst_q;
    assign idle                 = (state_q == ST_IDLE);
endmodule
